// File: rtl/wb_shared_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among N_MASTERS masters,
// with a per-transfer stall watchdog that aborts a stuck access with ERR.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   m_cyc/stb/we         per-master control, bit i = master i
//   m_adr/dat_w/sel      per-master address, write data, byte selects
//   m_cti/bte            per-master cycle/burst type
//   m_ack/err/dat_r      per-master response (only the owner sees any)
//   s_*                  shared slave port (muxed from the owner)
//   gnt                  one-hot owner, zero while idle
//   wdt_abort/wdt_id     abort pulse and index of last aborted master
module wb_shared_bus_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [N_MASTERS-1:0]                   m_cyc,
    input  logic [N_MASTERS-1:0]                   m_stb,
    input  logic [N_MASTERS-1:0]                   m_we,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
    input  logic [N_MASTERS*3-1:0]                 m_cti,
    input  logic [N_MASTERS*2-1:0]                 m_bte,
    output logic [N_MASTERS-1:0]                   m_ack,
    output logic [N_MASTERS-1:0]                   m_err,
    output logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_r,
    output logic                                   s_cyc,
    output logic                                   s_stb,
    output logic                                   s_we,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
    output logic [2:0]                             s_cti,
    output logic [1:0]                             s_bte,
    input  logic                                   s_ack,
    input  logic                                   s_err,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_r,
    output logic [N_MASTERS-1:0]                   gnt,
    output logic                                   wdt_abort,
    output logic [$clog2(N_MASTERS)-1:0]           wdt_id
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = $clog2(N_MASTERS);
    localparam int CW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, ABORT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] last_id_q, last_id_d;
    logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic [IW-1:0] wdt_id_q, wdt_id_d;

    logic          pick_vld;
    logic [IW-1:0] pick_id;
    logic [IW-1:0] cand;
    logic          stall;
    logic          wdt_hit;

    // Walk the rotation backwards so the nearest requester after
    // last_id is the final (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            cand = IW'((int'(last_id_q) + k) % N_MASTERS);
            if (m_cyc[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign stall = (state_q == GRANT) & m_cyc[gnt_id_q] & m_stb[gnt_id_q]
                 & ~s_ack & ~s_err;
    assign wdt_hit = stall && (TIMEOUT != 0) && (wdt_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            last_id_q <= IW'(N_MASTERS - 1);
            wdt_cnt_q <= '0;
            wdt_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            wdt_cnt_q <= wdt_cnt_d;
            wdt_id_q  <= wdt_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        wdt_cnt_d = wdt_cnt_q;
        wdt_id_d  = wdt_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = GRANT;
                    gnt_id_d  = pick_id;
                    last_id_d = pick_id;
                    wdt_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!m_cyc[gnt_id_q]) begin
                    state_d   = IDLE;
                    wdt_cnt_d = '0;
                end else if (wdt_hit) begin
                    // wdt_id must already show the victim during ABORT.
                    state_d   = ABORT;
                    wdt_id_d  = gnt_id_q;
                    wdt_cnt_d = '0;
                end else if (stall && (TIMEOUT != 0)) begin
                    wdt_cnt_d = wdt_cnt_q + CW'(1);
                end else begin
                    wdt_cnt_d = '0;
                end
            end
            ABORT: state_d = DRAIN;
            DRAIN: begin
                if (!m_cyc[gnt_id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_w   = '0;
        s_sel     = '0;
        s_cti     = '0;
        s_bte     = '0;
        m_ack     = '0;
        m_err     = '0;
        m_dat_r   = '0;
        gnt       = '0;
        wdt_abort = 1'b0;
        unique case (state_q)
            GRANT: begin
                s_cyc   = m_cyc[gnt_id_q];
                s_stb   = m_stb[gnt_id_q];
                s_we    = m_we[gnt_id_q];
                s_adr   = m_adr[int'(gnt_id_q)*AW +: AW];
                s_dat_w = m_dat_w[int'(gnt_id_q)*DW +: DW];
                s_sel   = m_sel[int'(gnt_id_q)*SW +: SW];
                s_cti   = m_cti[int'(gnt_id_q)*3 +: 3];
                s_bte   = m_bte[int'(gnt_id_q)*2 +: 2];
                m_ack[gnt_id_q] = s_ack;
                m_err[gnt_id_q] = s_err;
                m_dat_r[int'(gnt_id_q)*DW +: DW] = s_dat_r;
            end
            ABORT: begin
                m_err[gnt_id_q] = 1'b1;
                wdt_abort       = 1'b1;
            end
            default: ;
        endcase
        if (state_q != IDLE) gnt[gnt_id_q] = 1'b1;
    end

    assign wdt_id = wdt_id_q;

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Bench for wb_shared_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against an owner/stall-count reference model.
module tb_wb_shared_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat_w = '0;
    logic [N*SW-1:0] m_sel = '0;
    logic [N*3-1:0]  m_cti = '0;
    logic [N*2-1:0]  m_bte = '0;
    logic            s_ack = 1'b0, s_err = 1'b0;
    logic [DW-1:0]   s_dat_r = '0;

    logic [N-1:0]    m_ack, m_err, gnt;
    logic [N*DW-1:0] m_dat_r;
    logic            s_cyc, s_stb, s_we, wdt_abort;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [SW-1:0]   s_sel;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic [1:0]      wdt_id;

    logic [N-1:0]    m_ack_z, m_err_z, gnt_z;
    logic [N*DW-1:0] m_dat_r_z;
    logic            s_cyc_z, s_stb_z, s_we_z, wdt_abort_z;
    logic [AW-1:0]   s_adr_z;
    logic [DW-1:0]   s_dat_w_z;
    logic [SW-1:0]   s_sel_z;
    logic [2:0]      s_cti_z;
    logic [1:0]      s_bte_z;
    logic [1:0]      wdt_id_z;

    wb_shared_bus_arbiter #(
        .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
        .gnt(gnt), .wdt_abort(wdt_abort), .wdt_id(wdt_id)
    );

    wb_shared_bus_arbiter #(
        .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(0)
    ) dut0 (
        .clk(clk), .rstn(rstn),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack_z), .m_err(m_err_z), .m_dat_r(m_dat_r_z),
        .s_cyc(s_cyc_z), .s_stb(s_stb_z), .s_we(s_we_z), .s_adr(s_adr_z),
        .s_dat_w(s_dat_w_z), .s_sel(s_sel_z), .s_cti(s_cti_z),
        .s_bte(s_bte_z),
        .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
        .gnt(gnt_z), .wdt_abort(wdt_abort_z), .wdt_id(wdt_id_z)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner index (-1 = bus free), phase of the owner's
    // tenure (0 normal, 1 abort cycle, 2 draining), consecutive stalls.
    int m_own = -1, m_last = N - 1, m_phase = 0, m_stall = 0, m_wid = 0;

    logic [N-1:0]    e_gnt, e_mack, e_merr;
    logic [N*DW-1:0] e_mdat;
    logic            e_scyc, e_sstb, e_swe, e_abort;
    logic [AW-1:0]   e_sadr;
    logic [DW-1:0]   e_sdatw;
    logic [SW-1:0]   e_ssel;
    logic [2:0]      e_scti;
    logic [1:0]      e_sbte, e_wid;

    task automatic calc_exp();
        e_gnt = '0; e_mack = '0; e_merr = '0; e_mdat = '0;
        e_scyc = 0; e_sstb = 0; e_swe = 0; e_abort = 0;
        e_sadr = '0; e_sdatw = '0; e_ssel = '0; e_scti = '0; e_sbte = '0;
        e_wid = 2'(m_wid);
        if (m_own >= 0) begin
            e_gnt[m_own] = 1'b1;
            if (m_phase == 0) begin
                e_scyc  = m_cyc[m_own];
                e_sstb  = m_stb[m_own];
                e_swe   = m_we[m_own];
                e_sadr  = m_adr[m_own*AW +: AW];
                e_sdatw = m_dat_w[m_own*DW +: DW];
                e_ssel  = m_sel[m_own*SW +: SW];
                e_scti  = m_cti[m_own*3 +: 3];
                e_sbte  = m_bte[m_own*2 +: 2];
                e_mack[m_own] = s_ack;
                e_merr[m_own] = s_err;
                e_mdat[m_own*DW +: DW] = s_dat_r;
            end else if (m_phase == 1) begin
                e_merr[m_own] = 1'b1;
                e_abort = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_own = -1; m_last = N - 1; m_phase = 0; m_stall = 0; m_wid = 0;
        end else if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_cyc[(m_last + k) % N]) begin
                    m_own = (m_last + k) % N;
                    m_last = m_own;
                    m_stall = 0;
                    m_phase = 0;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (!m_cyc[m_own]) m_own = -1;
        end else if (!m_cyc[m_own]) begin
            m_own = -1;
        end else if (m_stb[m_own] && !s_ack && !s_err) begin
            m_stall++;
            if (m_stall == TO) begin
                m_phase = 1;
                m_wid = m_own;
            end
        end else begin
            m_stall = 0;
        end
    endtask

    bit act[N];
    int beats[N];
    bit resp[N];
    bit errf[N];

    task automatic sample();
        @(negedge clk);
        calc_exp();
        for (int i = 0; i < N; i++) begin
            resp[i] = e_mack[i] | e_merr[i];
            errf[i] = e_merr[i];
        end
        chk("gnt", gnt, e_gnt);
        chk("m_ack", m_ack, e_mack);
        chk("m_err", m_err, e_merr);
        chk("m_dat_r", m_dat_r, e_mdat);
        chk("s_cyc", s_cyc, e_scyc);
        chk("s_stb", s_stb, e_sstb);
        chk("s_we", s_we, e_swe);
        chk("s_adr", s_adr, e_sadr);
        chk("s_dat_w", s_dat_w, e_sdatw);
        chk("s_sel", s_sel, e_ssel);
        chk("s_cti", s_cti, e_scti);
        chk("s_bte", s_bte, e_sbte);
        chk("wdt_abort", wdt_abort, e_abort);
        chk("wdt_id", wdt_id, e_wid);
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic start_master(input int i, input int b);
        act[i] = 1'b1;
        beats[i] = b;
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i] = 1'($urandom_range(1));
        m_adr[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
        m_dat_w[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW] = 4'($urandom);
        m_cti[i*3 +: 3] = (b > 1) ? 3'b010 : 3'b000;
        m_bte[i*2 +: 2] = 2'($urandom);
    endtask

    task automatic masters_step(input int pstart);
        for (int i = 0; i < N; i++) begin
            if (act[i] && resp[i]) begin
                beats[i]--;
                if (beats[i] == 0 || errf[i]) begin
                    act[i] = 1'b0;
                    m_cyc[i] = 1'b0;
                    m_stb[i] = 1'b0;
                end else begin
                    m_adr[i*AW +: AW] = m_adr[i*AW +: AW] + 32'd4;
                    m_dat_w[i*DW +: DW] = $urandom;
                    m_cti[i*3 +: 3] = (beats[i] == 1) ? 3'b111 : 3'b010;
                end
            end else if (!act[i] && int'($urandom_range(99)) < pstart) begin
                start_master(i, int'($urandom_range(4, 1)));
            end
        end
    endtask

    task automatic slave_rand(input int pack, input int perr);
        calc_exp();
        s_ack = e_sstb && (int'($urandom_range(99)) < pack);
        s_err = e_sstb && !s_ack && (int'($urandom_range(99)) < perr);
        s_dat_r = $urandom;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
        return -1;
    endfunction

    int owners[$];
    int zruns[$];
    int zr;
    logic [N-1:0] pg;
    int cnt0100;
    logic [N-1:0] nxt;
    bit seen0100;
    bit any_act;
    int eo[5] = '{0, 1, 2, 3, 0};

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_gnt", gnt, 0);
        chk("reset_scyc", s_cyc, 0);

        // single read by master 0, acked on second strobe cycle
        start_master(0, 1);
        m_we[0] = 1'b0;
        step();
        sample();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_noack", m_ack, 0);
        advance();
        s_ack = 1'b1;
        s_dat_r = 32'hCAFE0001;
        sample();
        chk("t1_ack", m_ack, 4'b0001);
        chk("t1_dat", m_dat_r, 128'hCAFE0001);
        advance();
        s_ack = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        act[0] = 1'b0;
        step();
        step();

        // four continuous single-beat requesters
        do_reset();
        for (int i = 0; i < N; i++) start_master(i, 1);
        zr = 0;
        pg = '0;
        for (int c = 0; c < 30; c++) begin
            slave_rand(100, 0);
            sample();
            if (gnt != 0) begin
                if (pg == 0) begin
                    owners.push_back(oh2i(gnt));
                    if (owners.size() > 1) zruns.push_back(zr);
                end
                zr = 0;
            end else begin
                zr++;
            end
            pg = gnt;
            advance();
            masters_step(100);
        end
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k),
                (owners.size() > k) ? owners[k] : -1, eo[k]);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_gap%0d", k),
                (zruns.size() > k) ? zruns[k] : -1, 1);

        // burst by master 2 holds the bus against master 0
        do_reset();
        start_master(2, 4);
        cnt0100 = 0;
        seen0100 = 0;
        nxt = '0;
        for (int c = 0; c < 12; c++) begin
            slave_rand(100, 0);
            sample();
            if (gnt == 4'b0100) begin
                cnt0100++;
                seen0100 = 1;
            end else if (seen0100 && gnt != 0 && nxt == 0) begin
                nxt = gnt;
            end
            advance();
            masters_step(0);
            if (c == 0) start_master(0, 1);
        end
        chk("burst_hold", cnt0100, 5);
        chk("burst_next", nxt, 4'b0001);

        // watchdog abort on master 1
        do_reset();
        start_master(1, 1);
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c >= 1 && c <= 8) chk("wd_noabort", wdt_abort, 0);
            if (c == 9) begin
                chk("wd_err", m_err, 4'b0010);
                chk("wd_abort", wdt_abort, 1);
                chk("wd_id", wdt_id, 1);
                chk("wd_scyc", s_cyc, 0);
            end
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("drain_gnt", gnt, 4'b0010);
            chk("drain_err", m_err, 0);
            chk("drain_abort", wdt_abort, 0);
            advance();
        end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        act[1] = 1'b0;
        sample();
        chk("drain_last", gnt, 4'b0010);
        advance();
        sample();
        chk("drain_free", gnt, 0);
        chk("wd_id_hold", wdt_id, 1);
        advance();

        // ack in the last stall cycle beats the watchdog
        do_reset();
        start_master(1, 1);
        for (int c = 0; c < 11; c++) begin
            s_ack = (c == 8);
            s_dat_r = 32'h1234_5678;
            if (c == 9) begin
                m_cyc[1] = 1'b0;
                m_stb[1] = 1'b0;
                act[1] = 1'b0;
            end
            sample();
            if (c == 8) chk("late_ack", m_ack, 4'b0010);
            if (c >= 1) chk("late_noabort", wdt_abort, 0);
            if (c >= 1) chk("late_noerr", m_err, 0);
            advance();
        end
        s_ack = 1'b0;

        // watchdog disabled never aborts
        do_reset();
        start_master(1, 1);
        for (int c = 0; c < 1000; c++) begin
            sample();
            chk("wd0_abort", wdt_abort_z, 0);
            chk("wd0_err", m_err_z, 0);
            advance();
        end
        sample();
        chk("wd0_gnt", gnt_z, 4'b0010);
        chk("wd0_scyc", s_cyc_z, 1);
        advance();
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        act[1] = 1'b0;
        step();
        step();

        // reset during master 3 burst
        do_reset();
        start_master(3, 4);
        for (int c = 0; c < 3; c++) begin
            slave_rand(100, 0);
            sample();
            advance();
            masters_step(0);
        end
        rstn = 1'b0;
        s_ack = 1'b0;
        s_err = 1'b0;
        sample();
        chk("rst_pre_scyc", s_cyc, 1);
        chk("rst_pre_gnt", gnt, 4'b1000);
        advance();
        rstn = 1'b1;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0;
            start_master(i, 1);
        end
        sample();
        chk("rst_scyc", s_cyc, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_err", m_err, 0);
        advance();
        sample();
        chk("rst_first", gnt, 4'b0001);
        advance();
        masters_step(30);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            slave_rand(70, 5);
            sample();
            advance();
            masters_step(30);
        end
        any_act = 1'b1;
        for (int c = 0; c < 500 && any_act; c++) begin
            slave_rand(100, 0);
            sample();
            advance();
            masters_step(0);
            any_act = 1'b0;
            for (int i = 0; i < N; i++) any_act |= act[i];
        end
        chk("all_served", any_act, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
